// File: rtl/faultsim_arith_pkg.sv
// Shared definitions for the fault-simulation arithmetic units.
// Holds the serial-unit FSM encoding and the bit-counter width helper.
// No logic; imported by the serial borrow-restore datapath.
package faultsim_arith_pkg;

  // Serial-unit control states; encodings are fixed so fault lists stay stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a given operand width (at least 1 bit).
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Purpose: one-bit full adder built only from xor/and/or gate primitives.
// Latency: purely combinational.
// Backpressure: none.
// Ports: s (sum), co (carry out), a/b (operand bits), ci (carry in).
module fa_cell (
  output logic s,
  output logic co,
  input  logic a,
  input  logic b,
  input  logic ci
);

  logic axb;
  logic ab;
  logic cp;

  // Kept as explicit gates so each net is a distinct stuck-at fault site.
  xor g_x1 (axb, a, b);
  xor g_x2 (s, axb, ci);
  and g_a1 (ab, a, b);
  and g_a2 (cp, axb, ci);
  or  g_o1 (co, ab, cp);

endmodule

// File: rtl/bit_serial_borrow_restore.sv
// Purpose: rebuilds minuend A = (D + B) mod 2^WIDTH serially, LSB first;
//          final carry equals the borrow-out of the original A - B.
// Latency: start accepted at edge T -> done pulse in the cycle after edge T+WIDTH.
// Backpressure: none; start is only honoured in IDLE and ignored otherwise.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               request, sampled only when idle
//   diff_in, subt_in    difference D and subtrahend B, latched on accept
//   busy                high while bits are being processed
//   done                one-cycle pulse when sum_out/carry_out are updated
//   sum_out, carry_out  reconstructed A and final carry, held until next result
module bit_serial_borrow_restore
  import faultsim_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] diff_in,
  input  logic [WIDTH-1:0] subt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             step;
  logic             last;

  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;

  logic             fa_s;
  logic             fa_co;

  fa_cell u_fa (
    .s  (fa_s),
    .co (fa_co),
    .a  (d_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q)
  );

  assign last     = (cnt_q == CNT_LAST);
  // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at index 0.
  assign res_next = {fa_s, res_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode; busy/done depend only on state.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: operand shifters, carry FF, counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else if (load) begin
      d_sr    <= diff_in;
      b_sr    <= subt_in;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (step) begin
      d_sr    <= d_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= res_next;
      carry_q <= fa_co;
      cnt_q   <= cnt_q + CW'(1);
      // Publish on the SHIFT->DONE edge, including the final bit, so the
      // outputs are already valid while done is high.
      if (last) begin
        sum_out   <= res_next;
        carry_out <= fa_co;
      end
    end
  end

endmodule

// File: tb/tb_bit_serial_borrow_restore.sv
module tb_bit_serial_borrow_restore;

  typedef struct {
    logic [7:0] s;
    logic       c;
    longint     t;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start8, start2;
  logic [7:0] diff8, subt8, sum8;
  logic [1:0] diff2, subt2, sum2;
  logic       busy8, done8, carry8;
  logic       busy2, done2, carry2;

  exp_t q8[$];
  exp_t q2[$];
  exp_t e8, e2;

  int n_cmp = 0;
  int n_bad = 0;

  bit_serial_borrow_restore #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .diff_in(diff8), .subt_in(subt8),
    .busy(busy8), .done(done8), .sum_out(sum8), .carry_out(carry8)
  );

  bit_serial_borrow_restore #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .diff_in(diff2), .subt_in(subt2),
    .busy(busy2), .done(done2), .sum_out(sum2), .carry_out(carry2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: compare whenever a done pulse is presented.
  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("u8_unexpected_done", 1, 0);
      end else begin
        e8 = q8.pop_front();
        chk("u8_sum", {56'd0, sum8}, {56'd0, e8.s});
        chk("u8_carry", {63'd0, carry8}, {63'd0, e8.c});
        chk("u8_latency", $time - e8.t, 64'd85);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        chk("u2_unexpected_done", 1, 0);
      end else begin
        e2 = q2.pop_front();
        chk("u2_sum", {62'd0, sum2}, {62'd0, e2.s[1:0]});
        chk("u2_carry", {63'd0, carry2}, {63'd0, e2.c});
        chk("u2_latency", $time - e2.t, 64'd25);
      end
    end
  end

  // Present an operation for one edge and queue its expected result.
  task automatic issue8(input logic [7:0] d, input logic [7:0] b,
                        input logic [7:0] exp_s, input logic exp_c);
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; diff8 = d; subt8 = b;
    @(posedge clk);
    e.s = exp_s; e.c = exp_c; e.t = $time;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; diff8 = 8'($urandom); subt8 = 8'($urandom);
    chk("u8_accept_busy", {63'd0, busy8}, 64'd1);
  endtask

  task automatic wait_idle8();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy8 && !done8) return;
    end
    chk("u8_idle_timeout", 1, 0);
  endtask

  task automatic run2(input logic [1:0] d, input logic [1:0] b,
                      input logic [1:0] exp_s, input logic exp_c);
    exp_t e;
    @(negedge clk);
    start2 = 1'b1; diff2 = d; subt2 = b;
    @(posedge clk);
    e.s = {6'd0, exp_s}; e.c = exp_c; e.t = $time;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy2 && !done2) return;
    end
    chk("u2_idle_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    logic [1:0] dd;
    rst_n = 1'b0;
    start8 = 1'b0; diff8 = '0; subt8 = '0;
    start2 = 1'b0; diff2 = '0; subt2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy8}, 64'd0);
    chk("rst_done", {63'd0, done8}, 64'd0);
    chk("rst_sum", {56'd0, sum8}, 64'd0);
    chk("rst_carry", {63'd0, carry8}, 64'd0);
    rst_n = 1'b1;

    // 1: basic add, busy for exactly WIDTH cycles
    issue8(8'h05, 8'h03, 8'h08, 1'b0);
    busy_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy8) busy_cnt++;
      if (done8) break;
    end
    chk("u8_busy_cycles", busy_cnt, 8);
    wait_idle8();

    // 2: wrap with carry; 3: all zeros
    issue8(8'hFF, 8'h01, 8'h00, 1'b1);
    wait_idle8();
    issue8(8'h00, 8'h00, 8'h00, 1'b0);
    wait_idle8();

    // 4: starts during SHIFT (edge T+3) and DONE (edge T+9) are ignored
    issue8(8'h3C, 8'h0A, 8'h46, 1'b0);
    repeat (2) @(negedge clk);
    start8 = 1'b1; diff8 = 8'h11; subt8 = 8'h22;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    chk("u8_in_done_state", {63'd0, done8}, 64'd1);
    start8 = 1'b1; diff8 = 8'h33; subt8 = 8'h44;
    @(negedge clk);
    start8 = 1'b0;
    chk("u8_ignored_start_idle", {63'd0, busy8}, 64'd0);
    chk("u8_hold_sum", {56'd0, sum8}, 64'h46);
    issue8(8'h80, 8'h80, 8'h00, 1'b1);
    wait_idle8();

    // 5: reset mid-SHIFT clears everything and suppresses done
    issue8(8'hA5, 8'h5A, 8'hFF, 1'b0);
    wait_idle8();
    issue8(8'h12, 8'h34, 8'h46, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    void'(q8.pop_back());
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy8}, 64'd0);
    chk("midrst_done", {63'd0, done8}, 64'd0);
    chk("midrst_sum", {56'd0, sum8}, 64'd0);
    chk("midrst_carry", {63'd0, carry8}, 64'd0);
    rst_n = 1'b1;
    issue8(8'hC8, 8'h64, 8'h2C, 1'b1);
    wait_idle8();

    // 6: WIDTH=2 exhaustive round trip from A and B
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        dd = 2'(a - b);
        run2(dd, 2'(b), 2'(a), (a < b));
      end
    end

    repeat (3) @(negedge clk);
    chk("u8_queue_drained", q8.size(), 0);
    chk("u2_queue_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
